nibble_demux4: RTL and testbench

NIBBLE_DEMUX4 -- requirements
Module: nibble_demux4

---
 rtl/nibble_demux4_pkg.sv | 12 +
 rtl/nibble_slot_dec.sv | 15 +
 rtl/nibble_demux4.sv | 106 ++++++++++
 tb/tb_nibble_demux4.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_demux4_pkg.sv
// Shared widths and FSM encodings for the nibble-to-word demultiplexer.
package nibble_demux4_pkg;
  localparam int SEL_W  = 2;
  localparam int WORD_W = 16;
  localparam int NIB_W  = 4;
  localparam int SLOTS  = WORD_W / NIB_W;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/nibble_slot_dec.sv
// Combinational decode of slot index plus accept strobe into one-hot slot write enables.
module nibble_slot_dec
  import nibble_demux4_pkg::*;
(
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_accept,
  output logic [SLOTS-1:0] o_we
);

  always_comb begin
    o_we        = '0;
    o_we[i_sel] = i_accept;
  end

endmodule

// File: rtl/nibble_demux4.sv
// Packs four accepted nibbles into a 16-bit word, presented 1 cycle after the 4th accept and held until out_ready.
// NIBBLE_DEMUX4_DBUF_EN: separate collection register keeps accepting while a word waits (in_ready then registered-only).
module nibble_demux4
  import nibble_demux4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [NIB_W-1:0]  in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready
);

`ifdef NIBBLE_DEMUX4_DBUF_EN
  localparam int COLL_SLOTS = SLOTS;
`else
  localparam int COLL_SLOTS = SLOTS - 1;
`endif

  logic [SEL_W-1:0]                  r_sel;
  logic [COLL_SLOTS-1:0][NIB_W-1:0]  r_slot;
  logic                              r_out_valid;
  logic [WORD_W-1:0]                 r_out_data;
  logic                              w_accept;
  logic                              w_out_free;
  logic [SLOTS-1:0]                  w_we;
  logic                              w_hold_fill;

  assign w_accept   = in_valid & in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  nibble_slot_dec u_slot_dec (
    .i_sel    (r_sel),
    .i_accept (w_accept),
    .o_we     (w_we)
  );

`ifdef NIBBLE_DEMUX4_DBUF_EN
  state_e r_state;
  state_e w_state_nxt;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_FILL;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_we[SLOTS-1] && !w_out_free) w_state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready    = rst & ~flush & (r_state == ST_FILL);
    w_hold_fill = (r_state == ST_FILL);
  end
`else
  always_comb begin
    in_ready    = rst & ~flush & w_out_free;
    w_hold_fill = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sel       <= '0;
      r_slot      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      // In HOLD the collection register is the pending word, so flush must leave it alone.
      if (flush) begin
        r_sel <= '0;
        if (w_hold_fill) r_slot <= '0;
      end else if (w_accept) begin
        r_sel <= r_sel + SEL_W'(1);
      end
      for (int i = 0; i < COLL_SLOTS; i++) begin
        if (w_we[i]) r_slot[i] <= in_data;
      end
      if (w_we[SLOTS-1] && w_out_free) begin
        r_out_valid <= 1'b1;
        r_out_data  <= {in_data, r_slot[SLOTS-2:0]};
`ifdef NIBBLE_DEMUX4_DBUF_EN
      end else if (!w_hold_fill && out_ready) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_slot;
`endif
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_nibble_demux4.sv
// Randomised and directed bench for nibble_demux4 against a queue-based word-assembly model.
module tb_nibble_demux4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic [1:0]  sel;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  logic [3:0]  m_col[$];
  logic        m_ov = 1'b0;
  logic [15:0] m_od = 16'h0;
  logic        m_held = 1'b0;
  logic [15:0] m_hw = 16'h0;

  nibble_demux4 dut (
    .clk       (clk),
    .rst       (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
`ifdef NIBBLE_DEMUX4_DBUF_EN
    return rst_n & ~flush & ~m_held;
`else
    return rst_n & ~flush & (~m_ov | out_ready);
`endif
  endfunction

  // Model step at a rising edge, using the inputs present during the cycle.
  task automatic model_edge();
    logic        acc;
    logic [15:0] w;
    bit          done;
    acc  = in_valid & exp_ready();
    done = 0;
    w    = 16'h0;
    if (!rst_n) begin
      m_col.delete();
      m_ov = 0; m_od = 16'h0; m_held = 0; m_hw = 16'h0;
      return;
    end
    if (flush) m_col.delete();
    if (acc) begin
      m_col.push_back(in_data);
      if (m_col.size() == 4) begin
        w = {m_col[3], m_col[2], m_col[1], m_col[0]};
        m_col.delete();
        done = 1;
      end
    end
`ifdef NIBBLE_DEMUX4_DBUF_EN
    if (done && (!m_ov || out_ready)) begin m_od = w; m_ov = 1; end
    else if (done) begin m_held = 1; m_hw = w; end
    else if (m_held && out_ready) begin m_od = m_hw; m_held = 0; end
    else if (out_ready) m_ov = 0;
`else
    if (done) begin m_od = w; m_ov = 1; end
    else if (out_ready) m_ov = 0;
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] es;
      es = 16'(m_col.size());
      check("cyc_out_valid", {15'h0, out_valid}, {15'h0, m_ov});
      if (m_ov) check("cyc_out_data", out_data, m_od);
      check("cyc_sel", {14'h0, sel}, es);
      check("cyc_in_ready", {15'h0, in_ready}, {15'h0, exp_ready()});
    end
  end

  task automatic cyc(input logic v, input logic [3:0] d, input logic f,
                     input logic ordy, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = ordy;
    rst_n     = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    in_valid = 0; in_data = 0; flush = 0; out_ready = 1; rst_n = 0;
    // Reset held for two cycles
    cyc(0, 4'h0, 0, 1, 0);
    chk_en = 1;
    cyc(0, 4'h0, 0, 1, 0);
    check("rst_out_valid", {15'h0, out_valid}, 16'h0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_sel", {14'h0, sel}, 16'h0);
    check("rst_in_ready", {15'h0, in_ready}, 16'h0);
    cyc(0, 4'h0, 0, 1, 1);
    check("rel_in_ready", {15'h0, in_ready}, 16'h1);

    // Basic assembly 1,2,3,4
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 4'(i), 0, 1, 1);
      check("basic_sel", {14'h0, sel}, 16'(i % 4));
    end
    check("basic_out_valid", {15'h0, out_valid}, 16'h1);
    check("basic_out_data", out_data, 16'h4321);

    // Back-pressure with A,B,C,D streamed
    for (int k = 0; k < 4; k++) cyc(1, 4'(10 + k), 0, 0, 1);
    check("bp_in_ready", {15'h0, in_ready}, 16'h0);
    check("bp_out_data", out_data, 16'h4321);
    check("bp_out_valid", {15'h0, out_valid}, 16'h1);
    cyc(0, 4'h0, 0, 1, 1);
`ifdef NIBBLE_DEMUX4_DBUF_EN
    check("bp_next_valid", {15'h0, out_valid}, 16'h1);
    check("bp_next_data", out_data, 16'hDCBA);
    cyc(0, 4'h0, 0, 1, 1);
`else
    check("bp_next_valid", {15'h0, out_valid}, 16'h0);
`endif
    check("bp_drained", {15'h0, out_valid}, 16'h0);

    // Flush with a competing nibble
    cyc(1, 4'h5, 0, 1, 1);
    cyc(1, 4'h6, 0, 1, 1);
    check("fl_sel_pre", {14'h0, sel}, 16'h2);
    cyc(1, 4'h7, 1, 1, 1);
    check("fl_in_ready", {15'h0, in_ready}, 16'h0);
    check("fl_sel", {14'h0, sel}, 16'h0);
    cyc(1, 4'h8, 0, 1, 1);
    cyc(1, 4'h9, 0, 1, 1);
    cyc(1, 4'hA, 0, 1, 1);
    cyc(1, 4'hB, 0, 1, 1);
    check("fl_out_valid", {15'h0, out_valid}, 16'h1);
    check("fl_out_data", out_data, 16'hBA98);

    // Word pending while the next one completes
    cyc(1, 4'hC, 0, 0, 1);
    cyc(1, 4'hD, 0, 0, 1);
    cyc(1, 4'hE, 0, 0, 1);
    cyc(1, 4'hF, 0, 1, 1);
`ifdef NIBBLE_DEMUX4_DBUF_EN
    check("sim_out_valid", {15'h0, out_valid}, 16'h1);
    check("sim_out_data", out_data, 16'hFEDC);
`else
    check("sim_out_valid", {15'h0, out_valid}, 16'h0);
    check("sim_sel", {14'h0, sel}, 16'h1);
`endif
    cyc(0, 4'h0, 1, 1, 1);
    check("sim_flush_sel", {14'h0, sel}, 16'h0);

    // Mid-word reset
    cyc(1, 4'h1, 0, 1, 1);
    cyc(1, 4'h2, 0, 1, 1);
    cyc(0, 4'h0, 0, 1, 0);
    check("mr_sel", {14'h0, sel}, 16'h0);
    check("mr_out_valid", {15'h0, out_valid}, 16'h0);
    for (int i = 3; i <= 6; i++) begin
      if (i < 6) cyc(1, 4'(i), 0, 1, 1);
      else       cyc(1, 4'(i), 0, 1, 1);
      if (i < 6) check("mr_no_spurious", {15'h0, out_valid}, 16'h0);
    end
    check("mr_out_valid_new", {15'h0, out_valid}, 16'h1);
    check("mr_out_data_new", out_data, 16'h6543);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(3) != 0), 4'($urandom_range(15)),
          ($urandom_range(15) == 0), ($urandom_range(2) != 0),
          ($urandom_range(199) != 0));
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
